// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed 8-digit scan controller: digit select rotation, anode drive
// with inter-digit blanking, brightness dimming and per-digit blink.
module digit_scan_ctrl #(
    parameter int unsigned TICKS_PER_DIGIT = 100000,
    parameter int unsigned BLANK_TICKS     = 1000,
    parameter int unsigned BLINK_FRAMES    = 62
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [2:0] brightness,
    input  logic [7:0] blink_mask,
    output logic [7:0] SEL_digit,
    output logic [7:0] anode_n,
    output logic [2:0] digit_idx,
    output logic       frame_tick
);

    localparam int unsigned TW      = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
    localparam int unsigned FW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned ON_SPAN = TICKS_PER_DIGIT - BLANK_TICKS;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_DIGIT - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [TW-1:0] tick_cnt, tick_nx;
    logic [FW-1:0] frame_cnt, frame_nx;
    logic          blink_phase, phase_nx;
    logic [2:0]    bright_q, bright_nx;
    logic [7:0]    mask_q, mask_nx;
    logic          first_q;
    logic [2:0]    idx_nx;
    logic [7:0]    sel_nx;
    logic [7:0]    anode_nx;
    logic          ft_nx;
    logic          advance;
    logic          wrap;
    logic          sample;
    logic [31:0]   on_len_nx;
    logic [31:0]   tick32_nx;
    logic          blink_off;
    logic          lit;

    // Next-state: slot counter, digit rotation, blink phase, per-slot sampling,
    // and the anode drive computed against the tick value it will accompany.
    always_comb begin
        advance   = en && (tick_cnt == TICK_LAST);
        wrap      = advance && (digit_idx == 3'd7);
        tick_nx   = tick_cnt;
        idx_nx    = digit_idx;
        sel_nx    = SEL_digit;
        frame_nx  = frame_cnt;
        phase_nx  = blink_phase;

        if (en) begin
            tick_nx = advance ? '0 : tick_cnt + TW'(1);
        end
        if (advance) begin
            idx_nx = digit_idx + 3'd1;
            sel_nx = {SEL_digit[0], SEL_digit[7:1]};
        end
        if (wrap) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_nx = '0;
                phase_nx = ~blink_phase;
            end else begin
                frame_nx = frame_cnt + FW'(1);
            end
        end

        sample    = first_q || advance;
        bright_nx = sample ? brightness : bright_q;
        mask_nx   = sample ? blink_mask : mask_q;

        on_len_nx = (ON_SPAN * (32'(bright_nx) + 32'd1)) >> 3;
        tick32_nx = 32'(tick_nx);
        blink_off = phase_nx && ((mask_nx & ~sel_nx) != 8'h00);
        lit       = en && (tick32_nx >= BLANK_TICKS)
                       && (tick32_nx < (BLANK_TICKS + on_len_nx)) && !blink_off;
        anode_nx  = lit ? sel_nx : 8'hFF;
        ft_nx     = wrap;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt    <= '0;
            digit_idx   <= 3'd0;
            SEL_digit   <= 8'b0111_1111;
            anode_n     <= 8'hFF;
            frame_tick  <= 1'b0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            bright_q    <= 3'd7;
            mask_q      <= 8'h00;
            first_q     <= 1'b1;
        end else begin
            tick_cnt    <= tick_nx;
            digit_idx   <= idx_nx;
            SEL_digit   <= sel_nx;
            anode_n     <= anode_nx;
            frame_tick  <= ft_nx;
            frame_cnt   <= frame_nx;
            blink_phase <= phase_nx;
            bright_q    <= bright_nx;
            mask_q      <= mask_nx;
            first_q     <= 1'b0;
        end
    end

endmodule

// File: doc/digit_scan_ctrl.md
Name: digit_scan_ctrl

Overview:
Time-multiplexed scan controller for the 8-digit 7-segment display. It generates the active-low one-hot digit select SEL_digit. The digit multiplexer consumes SEL_digit to pick the clock or alarm BCD value. The block also drives the physical anode lines, with an inter-digit blanking gap (ghost suppression), brightness dimming and per-digit blink for time/alarm edit mode.

Parameters:
TICKS_PER_DIGIT, 100000, clk cycles per digit slot (1 ms at 100 MHz); legal range >= 2.
BLANK_TICKS, 1000, cycles at the start of each slot with anodes off; must be < TICKS_PER_DIGIT.
BLINK_FRAMES, 62, full 8-digit frames per blink half-period (about 0.5 s).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  synchronous active-low reset.
en  in  1  scan enable; low = display off, scan frozen.
brightness  in  3  duty code 0..7; on-time = (code+1)/8 of the unblanked window.
blink_mask  in  8  bit i = 1: digit whose SEL_digit bit i is low blinks.
SEL_digit  out  8  active-low one-hot digit select to the digit mux; never all-ones after reset.
anode_n  out  8  active-low anode drive; SEL_digit gated by blank/dim/blink.
digit_idx  out  3  current slot index 0..7; idx k ⇔ SEL_digit bit (7-k) low.
frame_tick  out  1  one-cycle pulse at each frame start.

Behaviour:
- All state and outputs are registered. Reset is synchronous, sampled on the clk rising edge with rst_n=0. Reset values:
  - tick_cnt=0, digit_idx=0, SEL_digit=8'b01111111, anode_n=8'hFF, frame_tick=0.
  - frame_cnt=0, blink_phase=0 (visible).
  - bright_q=7, mask_q=0.
- Reset mid-slot returns immediately to the reset state on the next edge. There is no partial-slot recovery.
- Slot counter: tick_cnt counts 0..TICKS_PER_DIGIT-1 while en=1. At the terminal count:
  - tick_cnt goes to 0.
  - digit_idx increments modulo 8.
  - SEL_digit rotates right by one: 01111111 → 10111111 → … → 11111110 → 01111111 (wrap).
  - SEL_digit and digit_idx change on the same edge at which tick_cnt becomes 0, so the mux output settles during the blank window.
- Per-slot sampling:
  - On every edge where tick_cnt becomes 0, and on the first edge after reset, bright_q←brightness and mask_q←blink_mask.
  - Mid-slot changes to these inputs take effect only in the next slot.
- on_len = ((TICKS_PER_DIGIT-BLANK_TICKS)*(bright_q+1)) >> 3, using integer truncation. on_len=0 is legal and means that digit is dark.
- anode_n, aligned to tick_cnt in the same cycle:
  - anode_n = SEL_digit when en=1, BLANK_TICKS <= tick_cnt < BLANK_TICKS+on_len, and NOT (mask_q[7-digit_idx] & blink_phase).
  - Otherwise anode_n = 8'hFF.
  - Never more than one anode low; never two different anodes low on adjacent cycles without at least BLANK_TICKS all-off cycles between them.
- frame_tick: 1 for exactly the first cycle in which digit_idx=0 after a 7→0 wrap. It is not asserted at reset.
- Blink: on each frame_tick, frame_cnt increments. When frame_cnt reaches BLINK_FRAMES-1 and the wrap occurs, frame_cnt goes to 0 and blink_phase toggles. One blink period = 2*BLINK_FRAMES frames.
- en=0:
  - tick_cnt, digit_idx, SEL_digit, frame_cnt and blink_phase hold.
  - anode_n=8'hFF from the next edge; frame_tick=0.
  - When en returns to 1, counting resumes from the held tick_cnt with no skipped or repeated slot.
- Simultaneous events:
  - Terminal count plus en falling: the count does not advance (en wins).
  - Reset overrides everything.

Test Plan:
Bench params: TICKS_PER_DIGIT=16, BLANK_TICKS=4, BLINK_FRAMES=2.
1. Reset, en=1, brightness=7 → SEL_digit=7F and anode_n=FF for ticks 0..3, anode_n=7F for ticks 4..15. At cycle 16 SEL_digit=BF and digit_idx=1.
2. Run 128 cycles from reset → SEL_digit visits 7F,BF,DF,EF,F7,FB,FD,FE, then returns to 7F. A single frame_tick occurs at cycle 128; no two anodes are ever low at once.
3. brightness=1 (on_len=3) → anode low only at ticks 4..6 of each slot. Change brightness to 0 at tick 8 → the current slot is unaffected; the next slot has on_len=1 (tick 4 only).
4. blink_mask=8'h80 → after frame_tick #2, the digit-0 slot keeps anode_n=FF for all 16 ticks while the other digits light normally. After frame_tick #4, digit 0 is visible again.
5. en=0 at tick 9 of slot 3 for 20 cycles → anode_n=FF, SEL_digit stays EF, no frame_tick. After en=1, SEL_digit changes to F7 exactly 7 enabled cycles later.
6. rst_n=0 for one edge during slot 5 with blink_phase=1 → next cycle SEL_digit=7F, anode_n=FF, digit_idx=0, blink_phase=0, tick_cnt=0.
